// File: rtl/aes_pkg.sv
// Shared types, key-length decode, GF(2^8) doubling and the AES S-box table
// used by the sequential key schedule.
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_INV = 2'b11
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_DRAIN
    } state_e;

    // Byte x of the table lives at bits [2047-8x -: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Key-load / round-key stream bundle. AES_KEY_EXPAND_STORE_EN adds the
// round-key read port (rd_round / rd_data).
interface aes_key_expand_seq_if #(
    parameter int KEY_W = 256,
    parameter int RK_W  = 128
);
    logic             start;
    logic [1:0]       key_len;
    logic [KEY_W-1:0] key;
    logic             rk_valid;
    logic             rk_ready;
    logic [RK_W-1:0]  rk_data;
    logic [3:0]       rk_round;
    logic             rk_last;
    logic             busy;
    logic             err;
`ifdef AES_KEY_EXPAND_STORE_EN
    logic [3:0]       rd_round;
    logic [RK_W-1:0]  rd_data;

    modport master (output start, key_len, key, rk_ready, rd_round,
                    input  rk_valid, rk_data, rk_round, rk_last, busy, err, rd_data);
    modport slave  (input  start, key_len, key, rk_ready, rd_round,
                    output rk_valid, rk_data, rk_round, rk_last, busy, err, rd_data);
`else
    modport master (output start, key_len, key, rk_ready,
                    input  rk_valid, rk_data, rk_round, rk_last, busy, err);
    modport slave  (input  start, key_len, key, rk_ready,
                    output rk_valid, rk_data, rk_round, rk_last, busy, err);
`endif
endinterface

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // 2047 - 8*din folds to {~din, 3'b111}
    assign dout = SBOX[{~din, 3'b111} -: 8];
endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key schedule: one schedule word per cycle, round
// keys streamed over valid/ready. AES_KEY_EXPAND_STORE_EN adds a round-key file.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int KEY_W = 256,
    parameter int RK_W  = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_expand_seq_if.slave  bus
);
    state_e           state_reg, state_next;
    logic [KEY_W-1:0] key_reg;
    logic [2:0]       nk_m1_reg;
    logic [3:0]       nr_reg;
    logic [5:0]       i_reg;
    logic [2:0]       kmod_reg;
    logic [7:0]       rcon_reg;
    logic [31:0]      hist_reg [0:7];
    logic [RK_W-1:0]  rk_data_reg;
    logic [3:0]       rk_round_reg;
    logic             rk_valid_reg, rk_last_reg, err_reg;

    logic [31:0] sub_in, sub_out, t_word, w_new;
    logic        start_ok, completion, adv, load, last_load, handshake;

    assign start_ok   = (state_reg == ST_IDLE) && bus.start && (bus.key_len != KL_INV);
    assign completion = (i_reg[1:0] == 2'b11);
    assign handshake  = rk_valid_reg && bus.rk_ready;
    assign adv        = (state_reg == ST_GEN) && !(completion && rk_valid_reg && !bus.rk_ready);
    assign load       = adv && completion;
    assign last_load  = load && (i_reg[5:2] == nr_reg);

    // RotWord only applies on the i mod Nk == 0 step
    assign sub_in = (kmod_reg == 3'd0) ? {hist_reg[0][23:0], hist_reg[0][31:24]} : hist_reg[0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (.din(sub_in[8*gi +: 8]), .dout(sub_out[8*gi +: 8]));
        end
    endgenerate

    always_comb begin
        t_word = hist_reg[0];
        if (kmod_reg == 3'd0)
            t_word = sub_out ^ {rcon_reg, 24'h0};
        else if (nk_m1_reg == 3'd7 && kmod_reg == 3'd4)
            t_word = sub_out;
        w_new = (i_reg <= {3'b000, nk_m1_reg}) ? key_reg[KEY_W-1 -: 32]
                                               : hist_reg[nk_m1_reg] ^ t_word;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_ok)  state_next = ST_GEN;
            ST_GEN:   if (last_load) state_next = ST_DRAIN;
            ST_DRAIN: if (handshake) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg      <= '0;
            nk_m1_reg    <= '0;
            nr_reg       <= '0;
            i_reg        <= '0;
            kmod_reg     <= '0;
            rcon_reg     <= '0;
            rk_data_reg  <= '0;
            rk_round_reg <= '0;
            rk_valid_reg <= 1'b0;
            rk_last_reg  <= 1'b0;
            err_reg      <= 1'b0;
            for (int k = 0; k < 8; k++) hist_reg[k] <= '0;
        end else begin
            err_reg <= (state_reg == ST_IDLE) && bus.start && (bus.key_len == KL_INV);
            if (start_ok) begin
                key_reg   <= bus.key;
                nk_m1_reg <= 3'(nk_of(bus.key_len) - 4'd1);
                nr_reg    <= nr_of(bus.key_len);
                i_reg     <= '0;
                kmod_reg  <= '0;
                rcon_reg  <= 8'h01;
            end
            if (adv) begin
                for (int k = 7; k > 0; k--) hist_reg[k] <= hist_reg[k-1];
                hist_reg[0] <= w_new;
                key_reg     <= key_reg << 32;
                i_reg       <= i_reg + 6'd1;
                kmod_reg    <= (kmod_reg == nk_m1_reg) ? 3'd0 : kmod_reg + 3'd1;
                if (kmod_reg == 3'd0 && i_reg > {3'b000, nk_m1_reg})
                    rcon_reg <= xtime(rcon_reg);
            end
            // A new load takes priority over clearing, so accept+load has no bubble
            if (load) begin
                rk_data_reg  <= {hist_reg[2], hist_reg[1], hist_reg[0], w_new};
                rk_round_reg <= i_reg[5:2];
                rk_last_reg  <= (i_reg[5:2] == nr_reg);
                rk_valid_reg <= 1'b1;
            end else if (handshake) begin
                rk_valid_reg <= 1'b0;
            end
        end
    end

`ifdef AES_KEY_EXPAND_STORE_EN
    logic [RK_W-1:0] rf_reg [0:14];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 15; k++) rf_reg[k] <= '0;
        end else if (load) begin
            rf_reg[i_reg[5:2]] <= {hist_reg[2], hist_reg[1], hist_reg[0], w_new};
        end
    end

    assign bus.rd_data = (bus.rd_round > nr_reg) ? '0 : rf_reg[bus.rd_round];
`endif

    assign bus.rk_valid = rk_valid_reg;
    assign bus.rk_data  = rk_data_reg;
    assign bus.rk_round = rk_round_reg;
    assign bus.rk_last  = rk_last_reg;
    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.err      = err_reg;

endmodule
